resp_tx_arbiter: RTL and testbench
==================================

# resp_tx_arbiter

Shares the single UART response transmitter (send_resp / resp / tx_done of the UART command wrapper) among NUM_REQ independent response sources, e.g. command acknowledge, status report and error report. Each source posts one byte with a one-cycle pulse. The block holds one pending byte per source and grants the transmitter round-robin. It issues one send_resp pulse per byte and reports per-source completion and dropped-request overflow.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  one-cycle post pulse per requester
- req_data  in  8*NUM_REQ  byte for requester i on bits [8i+7:8i], sampled with req[i]
- clr_ovf  in  1  synchronous clear of all ovf bits
- tx_done  in  1  UART transmit-complete level (cleared by the UART on send_resp)
- send_resp  out  1  registered one-cycle transmit strobe to the UART
- resp  out  8  registered byte to transmit, stable from the send_resp cycle until done
- pend  out  NUM_REQ  requester i has a byte queued or in flight
- done  out  NUM_REQ  one-cycle pulse: requester i's byte finished
- ovf  out  NUM_REQ  sticky: a post to requester i was dropped
- busy  out  1  FSM not in IDLE

## Operation
- Per-requester slot: pend[i] plus an 8-bit data register. req[i] with pend[i]=0 loads the data and sets pend[i].
- req[i] with pend[i]=1 and slot i not completing that cycle: post dropped, data unchanged, ovf[i] set.
- req[i] in the same cycle as done for slot i: accepted, pend[i] stays 1, new data loaded, no ovf.
- clr_ovf clears all ovf. A simultaneous drop wins, so that ovf bit ends at 1.
- Round-robin: pointer last = index of the last granted requester, reset value NUM_REQ-1. Search order is last+1, last+2, … with wrap modulo NUM_REQ. The first requester with pend=1 wins.
- FSM states:
  - IDLE: if any pend, latch the grant index, load resp from that slot, update last -> SEND.
  - SEND: send_resp=1 for exactly this cycle -> GUARD.
  - GUARD: tx_done ignored, covering the UART clearing a stale tx_done -> WAIT.
  - WAIT: hold until tx_done=1. Then pulse done[grant], clear pend[grant] unless re-posted that cycle -> IDLE.
- Posts during SEND/GUARD/WAIT to the granted slot are drops unless in the completing cycle. Posts to other slots queue normally.
- resp is changed only on the IDLE->SEND transition.
- Requesters with pend=0 are skipped. With no pending slot, the FSM stays in IDLE and last is unchanged.

## Timing
- Reset values: send_resp=0, resp=8'h00, pend=0, done=0, ovf=0, busy=0, state IDLE, last=NUM_REQ-1, slot data 0.
- Reset mid-transfer aborts immediately with no done pulse. The UART shares rst_n.
- Post at cycle t with the block idle: pend at t+1, FSM grants at t+1, send_resp=1 at t+2.
- tx_done first seen high in WAIT at cycle k: done and pend clear at k+1, IDLE at k+1. Next send_resp at k+2 earliest.
- Back-to-back minimum per byte: SEND + GUARD + WAIT(≥1) + IDLE = 4 cycles plus UART frame time.
- done and send_resp are single-cycle pulses and never overlap.

## Test plan
- Single post: req[1]=1, req_data byte1=8'hA5 at idle -> send_resp at t+2 with resp=8'hA5; hold tx_done=0 for 20 cycles then 1 -> one done[1] pulse one cycle later, pend[1]=0.
- Round-robin: post all three bytes (8'h11, 8'h22, 8'h33) in one cycle after reset -> transmit order requester 0,1,2. Re-post 0 and 2 during byte 2 -> order continues 0 then 2, not 2 first.
- Overflow: req[0] twice while pend[0]=1 and not completing -> second post dropped, ovf[0]=1 sticky, original byte sent. clr_ovf -> ovf=0. clr_ovf concurrent with a new drop -> ovf stays 1.
- Completion-cycle re-post: req[2]=1 with 8'h5A in the done[2] cycle -> no ovf, pend[2] stays 1, 8'h5A sent next.
- Stale tx_done: hold tx_done=1 across SEND/GUARD, UART clears it one cycle after send_resp -> no premature done; done only after the real re-assertion.
- Reset mid-WAIT: assert rst_n=0 -> all outputs reset values immediately, no done pulse. After release, idle until a new req.

Source files
------------

// File: rtl/resp_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : resp_tx_arbiter_if
// Description : Bundle between the response sources, the UART response
//               transmitter and resp_tx_arbiter.
//               slave  - the arbiter side (consumes posts and tx_done,
//                        drives the strobe, byte and status vectors).
//               master - the environment side (requesters plus UART).
//               Signal names carry the arbiter's direction (i_ in, o_ out).
// Revision    : 1.0 - initial release
// ============================================================================
interface resp_tx_arbiter_if #(
    parameter int NUM_REQ = 3
) ();
    logic [NUM_REQ-1:0]   i_req;        // one-cycle post pulse per requester
    logic [8*NUM_REQ-1:0] i_req_data;   // byte i on [8i+7:8i]
    logic                 i_clr_ovf;    // clear all sticky overflow bits
    logic                 i_tx_done;    // UART transmit-complete level
    logic                 o_send_resp;  // one-cycle transmit strobe
    logic [7:0]           o_resp;       // byte being transmitted
    logic [NUM_REQ-1:0]   o_pend;       // byte queued or in flight
    logic [NUM_REQ-1:0]   o_done;       // one-cycle completion pulse
    logic [NUM_REQ-1:0]   o_ovf;        // sticky dropped-post flag
    logic                 o_busy;       // transfer in progress

    modport slave (
        input  i_req, i_req_data, i_clr_ovf, i_tx_done,
        output o_send_resp, o_resp, o_pend, o_done, o_ovf, o_busy
    );

    modport master (
        output i_req, i_req_data, i_clr_ovf, i_tx_done,
        input  o_send_resp, o_resp, o_pend, o_done, o_ovf, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/resp_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : resp_tx_arbiter
// Description : Round-robin sharing of one UART response transmitter among
//               NUM_REQ byte sources. One pending byte per source, one
//               send_resp strobe per byte, per-source done pulse and sticky
//               overflow flag for dropped posts.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               bus   - resp_tx_arbiter_if.slave (posts, UART handshake,
//                       status outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module resp_tx_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    resp_tx_arbiter_if.slave bus
);
    localparam int c_IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_IW-1:0] c_LAST_RST = c_IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_GUARD = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_IW-1:0]    r_last;
    logic [c_IW-1:0]    r_grant;
    logic               r_send;
    logic [7:0]         r_resp;
    logic [NUM_REQ-1:0] r_done;
    logic               r_busy;
    logic [NUM_REQ-1:0] r_pend;
    logic [NUM_REQ-1:0] r_ovf;
    logic [7:0]         r_data [NUM_REQ];

    logic               w_complete;
    logic [NUM_REQ-1:0] w_fin;
    logic [NUM_REQ-1:0] w_accept;
    logic [NUM_REQ-1:0] w_drop;
    logic [c_IW-1:0]    w_sel;
    logic [c_IW-1:0]    w_idx;
    logic               w_any;

    // The granted slot finishes in the WAIT cycle that sees tx_done.
    assign w_complete = (r_state == S_WAIT) && bus.i_tx_done;

    // A slot accepts a post when empty or when its byte finishes this very
    // cycle; any other post to an occupied slot is dropped.
    always_comb begin
        w_fin    = '0;
        w_accept = '0;
        w_drop   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_fin[i]    = w_complete && (r_grant == c_IW'(i));
            w_accept[i] = bus.i_req[i] && (!r_pend[i] || w_fin[i]);
            w_drop[i]   = bus.i_req[i] && r_pend[i] && !w_fin[i];
        end
    end

    // Round-robin search starting after r_last. Scanning from the farthest
    // offset down to the nearest lets the nearest pending slot win; offset
    // NUM_REQ is r_last itself, which therefore has lowest priority.
    always_comb begin
        w_sel = r_last;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = c_IW'((int'(r_last) + k) % NUM_REQ);
            if (r_pend[w_idx]) begin
                w_sel = w_idx;
                w_any = 1'b1;
            end
        end
    end

    // Per-slot storage: pending flag, byte, sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_ovf  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_data[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept[i]) begin
                    r_data[i] <= bus.i_req_data[8*i +: 8];
                    r_pend[i] <= 1'b1;
                end else if (w_fin[i]) begin
                    r_pend[i] <= 1'b0;
                end
                // A drop in the same cycle as clr_ovf leaves the bit set.
                if (w_drop[i]) begin
                    r_ovf[i] <= 1'b1;
                end else if (bus.i_clr_ovf) begin
                    r_ovf[i] <= 1'b0;
                end
            end
        end
    end

    // Transfer sequencer. GUARD exists so a tx_done left high from the
    // previous frame is not mistaken for completion of this one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= c_LAST_RST;
            r_grant <= '0;
            r_send  <= 1'b0;
            r_resp  <= 8'h00;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_send <= 1'b0;
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_sel;
                        r_last  <= w_sel;
                        r_resp  <= r_data[w_sel];
                        r_send  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_state <= S_GUARD;
                end
                S_GUARD: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.i_tx_done) begin
                        r_done[r_grant] <= 1'b1;
                        r_busy          <= 1'b0;
                        r_state         <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_send_resp = r_send;
    assign bus.o_resp      = r_resp;
    assign bus.o_pend      = r_pend;
    assign bus.o_done      = r_done;
    assign bus.o_ovf       = r_ovf;
    assign bus.o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_resp_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_resp_tx_arbiter
// Description : Directed scenarios plus randomized traffic for
//               resp_tx_arbiter, compared every cycle against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resp_tx_arbiter;
    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    resp_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    resp_tx_arbiter #(.NUM_REQ(NR)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    // m_active: a byte owns the transmitter; m_age: cycles since its grant
    // (0 = strobe cycle, 1 = guard cycle, >=2 = waiting for tx_done).
    logic [7:0]    m_data [NR];
    logic [NR-1:0] m_pend, m_ovf, m_done;
    int            m_last, m_grant, m_age;
    logic          m_active;
    logic [7:0]    m_resp;

    logic [7:0]    sent [$];
    logic [NR-1:0] s_pend, s_done, s_ovf;
    logic          s_busy;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_data[i] = 8'h00;
        m_pend = '0; m_ovf = '0; m_done = '0;
        m_last = NR - 1; m_grant = 0; m_age = 0;
        m_active = 1'b0; m_resp = 8'h00;
    endtask

    task automatic model_step(input logic [NR-1:0] rq, input logic [8*NR-1:0] rd,
                              input logic clr, input logic txd);
        logic [NR-1:0] old_pend;
        logic          cmp;
        logic          found;
        int            g;
        old_pend = m_pend;
        cmp      = m_active && (m_age >= 2) && txd;
        m_done   = '0;
        if (clr) m_ovf = '0;
        for (int i = 0; i < NR; i++) begin
            if (rq[i]) begin
                if (!old_pend[i] || (cmp && m_grant == i)) begin
                    m_data[i] = rd[8*i +: 8];
                    m_pend[i] = 1'b1;
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end else if (cmp && m_grant == i) begin
                m_pend[i] = 1'b0;
            end
        end
        if (cmp) begin
            m_done[m_grant] = 1'b1;
            m_active = 1'b0;
        end else if (m_active) begin
            m_age++;
        end else begin
            found = 1'b0;
            for (int k = 1; k <= NR; k++) begin
                g = (m_last + k) % NR;
                if (!found && old_pend[g]) begin
                    found   = 1'b1;
                    m_grant = g;
                end
            end
            if (found) begin
                m_last   = m_grant;
                m_resp   = m_data[m_grant];
                m_active = 1'b1;
                m_age    = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".send"}, 32'(bus.o_send_resp), 32'(m_active && m_age == 0));
        chk({tag, ".resp"}, 32'(bus.o_resp), 32'(m_resp));
        chk({tag, ".pend"}, 32'(bus.o_pend), 32'(m_pend));
        chk({tag, ".done"}, 32'(bus.o_done), 32'(m_done));
        chk({tag, ".ovf"},  32'(bus.o_ovf),  32'(m_ovf));
        chk({tag, ".busy"}, 32'(bus.o_busy), 32'(m_active));
    endtask

    // One clock: drive, sample at negedge, advance model at posedge.
    task automatic cyc(input logic [NR-1:0] rq, input logic [8*NR-1:0] rd,
                       input logic clr, input logic txd);
        bus.i_req = rq; bus.i_req_data = rd; bus.i_clr_ovf = clr; bus.i_tx_done = txd;
        @(negedge clk);
        check_all("cyc");
        s_pend = bus.o_pend; s_done = bus.o_done; s_ovf = bus.o_ovf; s_busy = bus.o_busy;
        if (bus.o_send_resp) sent.push_back(bus.o_resp);
        @(posedge clk);
        model_step(rq, rd, clr, txd);
        #1;
    endtask

    task automatic idle(input int n, input logic txd);
        repeat (n) cyc('0, '0, 1'b0, txd);
    endtask

    // Idle until the model says the current byte is waiting for tx_done.
    task automatic run_to_wait(input string tag);
        int n = 0;
        while (!(m_active && m_age >= 2) && n < 20) begin
            cyc('0, '0, 1'b0, 1'b0);
            n++;
        end
        chk({tag, ".wait_timeout"}, 32'(n < 20), 32'(1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_req = '0; bus.i_req_data = '0; bus.i_clr_ovf = 1'b0; bus.i_tx_done = 1'b0;
        model_reset();
        sent.delete();
        #1;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_sent(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3,
                            input logic [7:0] e4, input int n);
        logic [7:0] exp [5];
        exp = '{e0, e1, e2, e3, e4};
        chk({tag, ".count"}, 32'(sent.size()), 32'(n));
        for (int k = 0; k < n && k < sent.size(); k++) begin
            chk({tag, ".byte"}, 32'(sent[k]), 32'(exp[k]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] rq;
        logic [31:0]   rnd;

        // Single post, long UART frame
        do_reset();
        cyc(3'b010, 24'h00A500, 1'b0, 1'b0);
        run_to_wait("single");
        idle(20, 1'b0);
        chk("single.no_early_done", 32'(s_done), 32'(0));
        cyc('0, '0, 1'b0, 1'b1);
        idle(1, 1'b0);
        chk("single.done", 32'(s_done), 32'(3'b010));
        chk("single.pend", 32'(s_pend), 32'(0));
        idle(2, 1'b0);
        chk_sent("single", 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 1);

        // Round-robin with re-posts during requester 2's byte
        do_reset();
        cyc(3'b111, 24'h332211, 1'b0, 1'b0);
        run_to_wait("rr0"); cyc('0, '0, 1'b0, 1'b1);
        run_to_wait("rr1"); cyc('0, '0, 1'b0, 1'b1);
        run_to_wait("rr2");
        cyc(3'b001, 24'h000044, 1'b0, 1'b0);
        cyc(3'b100, 24'h660000, 1'b0, 1'b1);
        run_to_wait("rr3"); cyc('0, '0, 1'b0, 1'b1);
        run_to_wait("rr4"); cyc('0, '0, 1'b0, 1'b1);
        idle(3, 1'b0);
        chk("rr.ovf", 32'(s_ovf), 32'(0));
        chk_sent("rr", 8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 5);

        // Overflow, clear, clear colliding with a drop
        do_reset();
        cyc(3'b001, 24'h000077, 1'b0, 1'b0);
        run_to_wait("ovf0");
        cyc(3'b001, 24'h000088, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("ovf.set", 32'(s_ovf), 32'(3'b001));
        cyc('0, '0, 1'b0, 1'b1);
        idle(1, 1'b0);
        cyc('0, '0, 1'b1, 1'b0);
        idle(1, 1'b0);
        chk("ovf.clr", 32'(s_ovf), 32'(0));
        cyc(3'b001, 24'h000099, 1'b0, 1'b0);
        run_to_wait("ovf1");
        cyc(3'b001, 24'h0000AA, 1'b1, 1'b0);
        idle(1, 1'b0);
        chk("ovf.clr_vs_drop", 32'(s_ovf), 32'(3'b001));
        cyc('0, '0, 1'b0, 1'b1);
        idle(2, 1'b0);
        chk_sent("ovf", 8'h77, 8'h99, 8'h00, 8'h00, 8'h00, 2);

        // Re-post in the completion cycle
        do_reset();
        cyc(3'b100, 24'h120000, 1'b0, 1'b0);
        run_to_wait("repost");
        cyc(3'b100, 24'h5A0000, 1'b0, 1'b1);
        idle(1, 1'b0);
        chk("repost.done", 32'(s_done), 32'(3'b100));
        chk("repost.pend", 32'(s_pend), 32'(3'b100));
        chk("repost.ovf",  32'(s_ovf),  32'(0));
        run_to_wait("repost2");
        cyc('0, '0, 1'b0, 1'b1);
        idle(2, 1'b0);
        chk_sent("repost", 8'h12, 8'h5A, 8'h00, 8'h00, 8'h00, 2);

        // Stale tx_done held through SEND and GUARD
        do_reset();
        cyc(3'b010, 24'h003C00, 1'b0, 1'b1);
        idle(3, 1'b1);
        idle(5, 1'b0);
        chk("stale.no_done", 32'(s_done), 32'(0));
        chk("stale.busy", 32'(s_busy), 32'(1));
        cyc('0, '0, 1'b0, 1'b1);
        idle(1, 1'b0);
        chk("stale.done", 32'(s_done), 32'(3'b010));

        // Asynchronous reset while waiting for tx_done
        do_reset();
        cyc(3'b010, 24'h005500, 1'b0, 1'b0);
        run_to_wait("arst");
        bus.i_tx_done = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("arst.now");
        @(negedge clk);
        check_all("arst.hold");
        @(posedge clk);
        #1;
        bus.i_tx_done = 1'b0;
        rst_n = 1'b1;
        sent.delete();
        idle(5, 1'b0);
        chk("arst.idle", 32'(s_busy), 32'(0));
        chk("arst.nosend", 32'(sent.size()), 32'(0));

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++) rq[i] = ($urandom_range(5) == 0);
            rnd = $urandom();
            cyc(rq, rnd[8*NR-1:0], ($urandom_range(15) == 0), ($urandom_range(3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
